// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared widths and slot-owner state encoding for the PSRAM arbiter
package ram_arbiter_pkg;
   localparam int ADDR_W = 23;
   localparam int DATA_W = 16;
   typedef enum logic [1:0] {SYNC, PARK, CLI, CFG} state_t;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: client, config and ram_ctrl-side signals of the PSRAM arbiter
interface ram_arbiter_if #(parameter int NUM_REQ = 4);
   import ram_arbiter_pkg::*;
   logic [NUM_REQ-1:0]        cli_req;
   logic [NUM_REQ-1:0]        cli_we;
   logic [NUM_REQ*ADDR_W-1:0] cli_addr;
   logic [NUM_REQ*DATA_W-1:0] cli_wdata;
   logic [NUM_REQ-1:0]        cli_done;
   logic [DATA_W-1:0]         cli_rdata;
   logic                      cfg_req;
   logic [ADDR_W-1:0]         cfg_opcode;
   logic                      cfg_ack;
   logic                      mem_we;
   logic [31:0]               mem_addr;
   logic [DATA_W-1:0]         mem_wdata;
   logic [DATA_W-1:0]         mem_rdata;
   logic                      rdy;
   logic [ADDR_W-1:0]         op_code;
   logic                      reload;
   logic                      err_timeout;
   modport slave (
      input  cli_req, cli_we, cli_addr, cli_wdata, cfg_req, cfg_opcode, mem_rdata, rdy,
      output cli_done, cli_rdata, cfg_ack, mem_we, mem_addr, mem_wdata, op_code, reload, err_timeout
   );
   modport master (
      output cli_req, cli_we, cli_addr, cli_wdata, cfg_req, cfg_opcode, mem_rdata, rdy,
      input  cli_done, cli_rdata, cfg_ack, mem_we, mem_addr, mem_wdata, op_code, reload, err_timeout
   );
endinterface

// File: rtl/ram_rr_pick.sv
// ram_rr_pick: combinational round-robin search for the first eligible requester after ptr
module ram_rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  mask,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);
   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   // rot[0] is the requester right after ptr, so the lowest set bit wins
   always_comb begin
      dbl   = {req & ~mask, req & ~mask};
      rot   = N'(dbl >> (int'(ptr) + 1));
      valid = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            valid = 1'b1;
            idx   = IW'((int'(ptr) + 1 + i) % N);
         end
      end
   end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the free-running ram_ctrl slot stream between clients and a config port,
// switching mem_*/reload only right after each rdy pulse
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int                NUM_REQ   = 4,
   parameter logic [ADDR_W-1:0] PARK_ADDR = 23'h0,
   parameter int                TIMEOUT   = 255
) (
   input  logic          clk,
   input  logic          sys_rst,
   ram_arbiter_if.slave  bus
);
   localparam int IW = $clog2(NUM_REQ);
   state_t             state, state_n;
   logic [IW-1:0]      rr_ptr, k_q, pick_idx;
   logic [NUM_REQ-1:0] done_mask;
   logic               pick_v, cfg_ok;
   logic [7:0]         wd_cnt;
   ram_rr_pick #(.N(NUM_REQ)) u_pick (
      .req   (bus.cli_req),
      .mask  (done_mask),
      .ptr   (rr_ptr),
      .valid (pick_v),
      .idx   (pick_idx)
   );
   // the finishing client/config port is kept out of the decision made in its own completion cycle
   always_comb begin
      done_mask = (state == CLI) ? NUM_REQ'(1) << k_q : '0;
      cfg_ok    = bus.cfg_req && state != CFG;
      state_n   = !bus.rdy ? state : cfg_ok ? CFG : pick_v ? CLI : PARK;
   end
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state           <= SYNC;
         rr_ptr          <= IW'(NUM_REQ - 1);
         k_q             <= '0;
         wd_cnt          <= '0;
         bus.mem_we      <= 1'b0;
         bus.mem_addr    <= {9'b0, PARK_ADDR};
         bus.mem_wdata   <= '0;
         bus.op_code     <= '0;
         bus.reload      <= 1'b0;
         bus.cli_done    <= '0;
         bus.cli_rdata   <= '0;
         bus.cfg_ack     <= 1'b0;
         bus.err_timeout <= 1'b0;
      end else begin
         state        <= state_n;
         bus.reload   <= 1'b0;
         bus.cli_done <= '0;
         bus.cfg_ack  <= 1'b0;
         wd_cnt       <= bus.rdy ? '0 : (wd_cnt == 8'(TIMEOUT)) ? wd_cnt : wd_cnt + 8'd1;
         if (wd_cnt == 8'(TIMEOUT)) bus.err_timeout <= 1'b1;
         if (bus.rdy) begin
            bus.cli_done <= done_mask;
            bus.cfg_ack  <= state == CFG;
            if (state == CLI) bus.cli_rdata <= bus.mem_rdata;
            if (state_n == CFG) begin
               bus.op_code <= bus.cfg_opcode;
               bus.reload  <= 1'b1;
               bus.mem_we  <= 1'b0;
            end else if (state_n == CLI) begin
               k_q           <= pick_idx;
               rr_ptr        <= pick_idx;
               bus.mem_we    <= bus.cli_we[pick_idx];
               bus.mem_addr  <= {9'b0, bus.cli_addr[ADDR_W*pick_idx +: ADDR_W]};
               bus.mem_wdata <= bus.cli_wdata[DATA_W*pick_idx +: DATA_W];
            end else begin
               bus.mem_we   <= 1'b0;
               bus.mem_addr <= {9'b0, PARK_ADDR};
            end
         end
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench with a ram_ctrl slot model and a completion scoreboard
module tb_ram_arbiter;
   typedef struct {
      logic [4:0]  code;
      logic        chk_rd;
      logic [15:0] rdata;
   } exp_t;

   logic clk = 1'b0;
   logic sys_rst = 1'b1;
   always #5 clk = ~clk;

   ram_arbiter_if #(.NUM_REQ(4)) bus ();
   ram_arbiter #(.NUM_REQ(4), .PARK_ADDR(23'h0), .TIMEOUT(255)) dut (
      .clk     (clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   int tests = 0;
   int fails = 0;
   exp_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ram_ctrl model: rdy every 7 cycles, 30-cycle slot after a reload, optional stall
   bit [15:0] mem [bit [22:0]];
   int  m_cnt = 0;
   int  m_period = 7;
   logic stall = 1'b0;
   always @(negedge clk) begin
      if (bus.reload) m_period = 30;
      if (stall) bus.rdy = 1'b0;
      else if (m_cnt >= m_period - 1) begin
         bus.rdy = 1'b1;
         m_cnt = 0;
         m_period = 7;
         bus.mem_rdata = mem.exists(bus.mem_addr[22:0]) ? mem[bus.mem_addr[22:0]] : 16'h0;
         if (bus.mem_we) mem[bus.mem_addr[22:0]] = bus.mem_wdata;
      end else begin
         bus.rdy = 1'b0;
         m_cnt++;
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      if (bus.cli_done != 0 || bus.cfg_ack) begin
         if (q.size() == 0) chk("unexpected_done", {27'b0, bus.cfg_ack, bus.cli_done}, 32'h0);
         else begin
            exp_t e;
            e = q.pop_front();
            chk("done_order", {27'b0, bus.cfg_ack, bus.cli_done}, {27'b0, e.code});
            if (e.chk_rd) chk("rdata", {16'h0, bus.cli_rdata}, {16'h0, e.rdata});
         end
      end
   end

   // mem_* may only move on the edge that sampled rdy (or reset); reload must be single-cycle
   int stab_viol = 0, reload_viol = 0, reload_cycles = 0;
   logic [48:0] saved;
   logic have = 1'b0, prev_reload = 1'b0;
   always @(posedge clk) begin
      #1;
      if (have && !bus.rdy && !sys_rst && saved !== {bus.mem_we, bus.mem_addr, bus.mem_wdata}) stab_viol++;
      saved = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
      have = 1'b1;
      if (bus.reload) begin
         reload_cycles++;
         if (prev_reload) reload_viol++;
      end
      prev_reload = bus.reload;
   end

   task automatic set_cli(input int k, input logic we, input logic [22:0] a, input logic [15:0] d);
      bus.cli_we[k] = we;
      bus.cli_addr[23*k +: 23] = a;
      bus.cli_wdata[16*k +: 16] = d;
   endtask

   task automatic wait_done(input int k, input int lim, output int cyc);
      logic seen = 1'b0;
      cyc = 0;
      while (!seen && cyc < lim) begin
         @(negedge clk);
         cyc++;
         seen = bus.cli_done[k];
      end
      chk($sformatf("done_seen_%0d", k), {31'b0, seen}, 32'h1);
   endtask

   task automatic access(input int k, input logic we, input logic [22:0] a, input logic [15:0] d,
                         input logic chk_rd, input logic [15:0] rd);
      int cyc;
      exp_t e;
      set_cli(k, we, a, d);
      e.code = 5'(1 << k); e.chk_rd = chk_rd; e.rdata = rd;
      q.push_back(e);
      bus.cli_req[k] = 1'b1;
      wait_done(k, 200, cyc);
      bus.cli_req[k] = 1'b0;
   endtask

   task automatic wait_grant(input logic [22:0] a);
      logic seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         seen = bus.mem_we && bus.mem_addr == {9'b0, a};
      end
      chk("grant_seen", {31'b0, seen}, 32'h1);
   endtask

   task automatic do_reset();
      sys_rst = 1'b1;
      repeat (2) @(negedge clk);
      sys_rst = 1'b0;
   endtask

   initial begin
      exp_t e;
      int cyc, n, rc0;
      logic got_ack, got_done;
      bus.cli_req = '0; bus.cli_we = '0; bus.cli_addr = '0; bus.cli_wdata = '0;
      bus.cfg_req = 1'b0; bus.cfg_opcode = '0; bus.rdy = 1'b0; bus.mem_rdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
      chk("rst_mem_addr", bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", {16'h0, bus.mem_wdata}, 32'h0);
      chk("rst_op_code", {9'h0, bus.op_code}, 32'h0);
      chk("rst_reload", {31'b0, bus.reload}, 32'h0);
      chk("rst_done", {27'b0, bus.cfg_ack, bus.cli_done}, 32'h0);
      chk("rst_rdata", {16'h0, bus.cli_rdata}, 32'h0);
      chk("rst_err", {31'b0, bus.err_timeout}, 32'h0);
      sys_rst = 1'b0;
      // idle: park slots only
      repeat (30) @(negedge clk);
      chk("park_we", {31'b0, bus.mem_we}, 32'h0);
      chk("park_addr", bus.mem_addr, 32'h0);
      // client 1 write then read back
      access(1, 1'b1, 23'h000100, 16'hA5A5, 1'b0, 16'h0);
      access(1, 1'b0, 23'h000100, 16'h0000, 1'b1, 16'hA5A5);
      // all four clients contend from a fresh rr pointer: 0,1,2,3,0
      do_reset();
      for (int i = 0; i < 4; i++) set_cli(i, 1'b0, 23'(16 + i), 16'h0);
      foreach (e.code[i]) ;
      for (int i = 0; i < 5; i++) begin
         e.code = 5'(1 << (i % 4)); e.chk_rd = 1'b0; e.rdata = 16'h0;
         q.push_back(e);
      end
      bus.cli_req = 4'hF;
      n = 0;
      for (int i = 0; i < 300 && n < 5; i++) begin
         @(negedge clk);
         if (bus.cli_done != 0) n++;
         if (n == 4) bus.cli_req = 4'h0;
      end
      chk("rr_done_count", n, 5);
      // config beats a simultaneous client request
      repeat (10) @(negedge clk);
      rc0 = reload_cycles;
      e.code = 5'b10000; e.chk_rd = 1'b0; q.push_back(e);
      e.code = 5'b00100; q.push_back(e);
      set_cli(2, 1'b0, 23'h000200, 16'h0);
      bus.cfg_opcode = 23'h081D1F;
      bus.cfg_req = 1'b1;
      bus.cli_req[2] = 1'b1;
      got_ack = 1'b0; got_done = 1'b0;
      for (int i = 0; i < 300 && !(got_ack && got_done); i++) begin
         @(negedge clk);
         if (bus.cfg_ack) begin got_ack = 1'b1; bus.cfg_req = 1'b0; end
         if (bus.cli_done[2]) begin got_done = 1'b1; bus.cli_req[2] = 1'b0; end
      end
      chk("cfg_ack_seen", {31'b0, got_ack}, 32'h1);
      chk("cfg_cli2_seen", {31'b0, got_done}, 32'h1);
      chk("op_code", {9'h0, bus.op_code}, 32'h00081D1F);
      chk("reload_pulses", reload_cycles - rc0, 1);
      // watchdog during a stalled client-0 write
      e.code = 5'b00001; e.chk_rd = 1'b0; q.push_back(e);
      set_cli(0, 1'b1, 23'h000300, 16'h1234);
      bus.cli_req[0] = 1'b1;
      wait_grant(23'h000300);
      stall = 1'b1;
      repeat (200) @(negedge clk);
      chk("err_before_limit", {31'b0, bus.err_timeout}, 32'h0);
      repeat (100) @(negedge clk);
      chk("err_after_limit", {31'b0, bus.err_timeout}, 32'h1);
      stall = 1'b0;
      wait_done(0, 50, cyc);
      bus.cli_req[0] = 1'b0;
      chk("err_sticky", {31'b0, bus.err_timeout}, 32'h1);
      // reset in the middle of a client-0 write: aborted slot gives no done
      set_cli(0, 1'b1, 23'h000400, 16'hBEEF);
      bus.cli_req[0] = 1'b1;
      wait_grant(23'h000400);
      repeat (2) @(negedge clk);
      sys_rst = 1'b1;
      @(negedge clk);
      sys_rst = 1'b0;
      chk("err_cleared", {31'b0, bus.err_timeout}, 32'h0);
      chk("rst_abort_we", {31'b0, bus.mem_we}, 32'h0);
      e.code = 5'b00001; e.chk_rd = 1'b0; q.push_back(e);
      wait_done(0, 100, cyc);
      bus.cli_req[0] = 1'b0;
      chk("sync_skip", {31'b0, cyc >= 7}, 32'h1);
      access(0, 1'b0, 23'h000400, 16'h0, 1'b1, 16'hBEEF);
      repeat (20) @(negedge clk);
      chk("queue_empty", q.size(), 0);
      chk("mem_stable", stab_viol, 0);
      chk("reload_single", reload_viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
